segment_plotter: RTL and testbench

//   Parametrised rectangle-segment pixel generator for the hangman VGA path.

---
 rtl/hangman_gfx_pkg.sv | 59 +++++
 rtl/segment_plotter_if.sv | 17 +
 rtl/segment_table.sv | 27 ++
 rtl/segment_plotter.sv | 152 +++++++++++++++
 tb/tb_segment_plotter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hangman_gfx_pkg.sv
// Shared constants, segment packing and FSM encoding for the hangman graphics path.
package hangman_gfx_pkg;

  // Default field widths and table geometry
  localparam int unsigned GFX_X_W     = 8;
  localparam int unsigned GFX_Y_W     = 7;
  localparam int unsigned GFX_DIM_W   = 7;
  localparam int unsigned GFX_COL_W   = 3;
  localparam int unsigned GFX_NUM_SEG = 10;
  localparam int unsigned GFX_SEG_AW  = 4;
  localparam int unsigned GFX_SEG_W   = GFX_X_W + GFX_Y_W + 2 * GFX_DIM_W + GFX_COL_W;

  // Visible screen area
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  // Field LSB offsets inside a packed segment word {x0, y0, w, h, colour}
  localparam int unsigned SEG_COL_LSB = 0;
  localparam int unsigned SEG_H_LSB   = SEG_COL_LSB + GFX_COL_W;
  localparam int unsigned SEG_W_LSB   = SEG_H_LSB + GFX_DIM_W;
  localparam int unsigned SEG_Y0_LSB  = SEG_W_LSB + GFX_DIM_W;
  localparam int unsigned SEG_X0_LSB  = SEG_Y0_LSB + GFX_Y_W;

  // Draw modes: bit 0 = cumulative (0..idx), bit 1 = erase
  typedef enum logic [1:0] {
    MODE_DRAW_ONE   = 2'b00,
    MODE_DRAW_UPTO  = 2'b01,
    MODE_ERASE_ONE  = 2'b10,
    MODE_ERASE_UPTO = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PLOT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Default hangman segment indices
  localparam int unsigned SEG_GALLOWS_BASE = 0;
  localparam int unsigned SEG_GALLOWS_POST = 1;
  localparam int unsigned SEG_GALLOWS_BEAM = 2;
  localparam int unsigned SEG_GALLOWS_ROPE = 3;
  localparam int unsigned SEG_HEAD         = 4;
  localparam int unsigned SEG_TORSO        = 5;
  localparam int unsigned SEG_ARM_L        = 6;
  localparam int unsigned SEG_ARM_R        = 7;
  localparam int unsigned SEG_LEG_L        = 8;
  localparam int unsigned SEG_LEG_R        = 9;

  // Build a table write word from its fields
  function automatic logic [GFX_SEG_W-1:0] pack_seg(input int unsigned x0, input int unsigned y0,
                                                    input int unsigned w, input int unsigned h,
                                                    input int unsigned colour);
    return {GFX_X_W'(x0), GFX_Y_W'(y0), GFX_DIM_W'(w), GFX_DIM_W'(h), GFX_COL_W'(colour)};
  endfunction

endpackage

// File: rtl/segment_plotter_if.sv
// Pixel bus toward the VGA adapter: coordinates, colour, valid and ready.
interface segment_plotter_if
  import hangman_gfx_pkg::*;
#(
  parameter int unsigned X_W   = GFX_X_W,
  parameter int unsigned Y_W   = GFX_Y_W,
  parameter int unsigned COL_W = GFX_COL_W
);
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour;
  logic             plot;
  logic             plot_ready;

  modport master (output x, y, colour, plot, input plot_ready);
  modport slave  (input x, y, colour, plot, output plot_ready);
endinterface

// File: rtl/segment_table.sv
// Segment register file: one synchronous write port, one async read port, sync clear.
module segment_table #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SEG = 10,
  parameter int unsigned SEG_AW  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [SEG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [NUM_SEG];

  // Clear on reset; writes to addresses past the table are dropped
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i < NUM_SEG; i++) mem[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < NUM_SEG)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_addr) < NUM_SEG) ? mem[rd_addr] : '0;
endmodule

// File: rtl/segment_plotter.sv
// Rasters rectangles from the segment table onto the pixel bus, with erase and backpressure.
module segment_plotter
  import hangman_gfx_pkg::*;
#(
  parameter int unsigned X_W     = GFX_X_W,
  parameter int unsigned Y_W     = GFX_Y_W,
  parameter int unsigned DIM_W   = GFX_DIM_W,
  parameter int unsigned COL_W   = GFX_COL_W,
  parameter int unsigned NUM_SEG = GFX_NUM_SEG,
  parameter int unsigned SEG_AW  = GFX_SEG_AW,
  parameter int unsigned X_MAX   = SCREEN_W,
  parameter int unsigned Y_MAX   = SCREEN_H,
  localparam int unsigned SEG_W  = X_W + Y_W + 2 * DIM_W + COL_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [SEG_AW-1:0] part_idx,
  input  logic              seg_wr_en,
  input  logic [SEG_AW-1:0] seg_wr_addr,
  input  logic [SEG_W-1:0]  seg_wr_data,
  segment_plotter_if.master pix,
  output logic              busy,
  output logic              done
);
  state_t            state;
  logic [1:0]        mode_q;
  logic [SEG_AW-1:0] idx_q, seg_q, idx_c;
  logic [X_W-1:0]    x0_q;
  logic [Y_W-1:0]    y0_q;
  logic [DIM_W-1:0]  w_q, h_q, dx_q, dy_q, ndx_c, ndy_c;
  logic [COL_W-1:0]  col_q;
  logic              row_end_c, last_px_c;
  logic [31:0]       nx_c, ny_c;

  logic [SEG_W-1:0]  rd_data;
  logic [X_W-1:0]    t_x0;
  logic [Y_W-1:0]    t_y0;
  logic [DIM_W-1:0]  t_w, t_h;
  logic [COL_W-1:0]  t_col;

  segment_table #(.DATA_W(SEG_W), .NUM_SEG(NUM_SEG), .SEG_AW(SEG_AW)) u_table (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (seg_wr_en),
    .wr_addr (seg_wr_addr),
    .wr_data (seg_wr_data),
    .rd_addr (seg_q),
    .rd_data (rd_data)
  );

  assign t_x0  = rd_data[SEG_W-1 -: X_W];
  assign t_y0  = rd_data[SEG_W-X_W-1 -: Y_W];
  assign t_w   = rd_data[COL_W+2*DIM_W-1 -: DIM_W];
  assign t_h   = rd_data[COL_W+DIM_W-1 -: DIM_W];
  assign t_col = rd_data[COL_W-1:0];

  assign idx_c = (32'(part_idx) >= NUM_SEG) ? SEG_AW'(NUM_SEG - 1) : part_idx;

  // Next raster position (dx inner, dy outer) and its widened screen coordinate
  always_comb begin
    row_end_c = (dx_q == w_q - DIM_W'(1));
    last_px_c = row_end_c && (dy_q == h_q - DIM_W'(1));
    ndx_c     = row_end_c ? '0 : dx_q + DIM_W'(1);
    ndy_c     = row_end_c ? dy_q + DIM_W'(1) : dy_q;
    nx_c      = 32'(x0_q) + 32'(ndx_c);
    ny_c      = 32'(y0_q) + 32'(ndy_c);
  end

  // Control FSM; the pixel registers always hold the pixel currently offered
  always_ff @(posedge clk) begin
    if (resetn) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      idx_q      <= '0;
      seg_q      <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      col_q      <= '0;
      pix.x      <= '0;
      pix.y      <= '0;
      pix.colour <= '0;
      pix.plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            idx_q  <= idx_c;
            seg_q  <= mode[0] ? '0 : idx_c;
            busy   <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          x0_q  <= t_x0;
          y0_q  <= t_y0;
          w_q   <= t_w;
          h_q   <= t_h;
          col_q <= t_col;
          dx_q  <= '0;
          dy_q  <= '0;
          if (t_w == '0 || t_h == '0) begin
            state <= S_NEXT;
          end else begin
            pix.x      <= t_x0;
            pix.y      <= t_y0;
            pix.colour <= mode_q[1] ? '0 : t_col;
            pix.plot   <= (32'(t_x0) < X_MAX) && (32'(t_y0) < Y_MAX);
            state      <= S_PLOT;
          end
        end
        S_PLOT: begin
          // Off-screen slots (plot low) advance without waiting for the sink
          if (!pix.plot || pix.plot_ready) begin
            if (last_px_c) begin
              pix.plot <= 1'b0;
              state    <= S_NEXT;
            end else begin
              dx_q       <= ndx_c;
              dy_q       <= ndy_c;
              pix.x      <= X_W'(nx_c);
              pix.y      <= Y_W'(ny_c);
              pix.colour <= mode_q[1] ? '0 : col_q;
              pix.plot   <= (nx_c < X_MAX) && (ny_c < Y_MAX);
            end
          end
        end
        S_NEXT: begin
          if (!mode_q[0] || seg_q == idx_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            seg_q <= seg_q + SEG_AW'(1);
            state <= S_FETCH;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_segment_plotter.sv
// Scenario bench for segment_plotter: expected pixels are queued at start and compared after the draw.
module tb_segment_plotter;
  import hangman_gfx_pkg::*;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 start;
  logic [1:0]           mode;
  logic [3:0]           part_idx;
  logic                 seg_wr_en;
  logic [3:0]           seg_wr_addr;
  logic [GFX_SEG_W-1:0] seg_wr_data;
  logic                 busy, done;

  segment_plotter_if pix_bus ();

  segment_plotter dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .mode        (mode),
    .part_idx    (part_idx),
    .seg_wr_en   (seg_wr_en),
    .seg_wr_addr (seg_wr_addr),
    .seg_wr_data (seg_wr_data),
    .pix         (pix_bus),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  pix_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference copy of the segment table
  int m_x0[10], m_y0[10], m_w[10], m_h[10], m_c[10];

  // Results of the most recent draw
  int r_done_cyc, r_plot_cyc, r_done_pulses, r_held_bad;
  bit r_busy_at_done;

  function automatic void set_model(input int a, input int x0, input int y0, input int w,
                                    input int h, input int c);
    if (a < 10) begin
      m_x0[a] = x0; m_y0[a] = y0; m_w[a] = w; m_h[a] = h; m_c[a] = c;
    end
  endfunction

  task automatic wr_seg(input int a, input int x0, input int y0, input int w, input int h,
                        input int c);
    seg_wr_en   = 1'b1;
    seg_wr_addr = 4'(a);
    seg_wr_data = pack_seg(x0, y0, w, h, c);
    @(posedge clk); #1;
    seg_wr_en = 1'b0;
    set_model(a, x0, y0, w, h, c);
  endtask

  // Pulse start and queue every on-screen pixel the draw should hand over
  task automatic do_start(input logic [1:0] md, input int idx, output int exp_cyc);
    int ci, lo;
    ci = (idx >= 10) ? 9 : idx;
    lo = md[0] ? 0 : ci;
    exp_cyc = 1;
    for (int s = lo; s <= ci; s++) begin
      exp_cyc += m_w[s] * m_h[s] + 2;
      for (int dy = 0; dy < m_h[s]; dy++)
        for (int dx = 0; dx < m_w[s]; dx++)
          if (m_x0[s] + dx < 160 && m_y0[s] + dy < 120)
            exp_q.push_back(pix_t'{8'(m_x0[s] + dx), 7'(m_y0[s] + dy), md[1] ? 3'd0 : 3'(m_c[s])});
    end
    start    = 1'b1;
    mode     = md;
    part_idx = 4'(idx);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle n counts from the start edge; optional mid-draw table write and extra start pulse
  task automatic run_draw(input int budget, input int period, input int wr_n, input int wr_a,
                          input logic [GFX_SEG_W-1:0] wr_d, input int rs_n);
    bit   hold_prev;
    pix_t prev;
    int   n;
    r_done_cyc = 0; r_plot_cyc = 0; r_done_pulses = 0; r_held_bad = 0; r_busy_at_done = 1'b1;
    hold_prev = 1'b0; prev = '0; n = 0;
    while (n < budget && !(r_done_pulses > 0 && n >= r_done_cyc + 2)) begin
      n++;
      pix_bus.plot_ready = (period <= 1) || (n % period == 0);
      seg_wr_en = (n == wr_n);
      if (n == wr_n) begin seg_wr_addr = 4'(wr_a); seg_wr_data = wr_d; end
      start = (n == rs_n);
      if (n == rs_n) begin mode = 2'b00; part_idx = 4'd0; end
      @(negedge clk);
      if (hold_prev && (pix_bus.x !== prev.x || pix_bus.y !== prev.y)) r_held_bad++;
      hold_prev = pix_bus.plot && !pix_bus.plot_ready;
      prev = pix_t'{pix_bus.x, pix_bus.y, pix_bus.colour};
      if (pix_bus.plot) r_plot_cyc++;
      if (pix_bus.plot && pix_bus.plot_ready) obs_q.push_back(prev);
      if (done) begin
        if (r_done_pulses == 0) begin r_done_cyc = n; r_busy_at_done = busy; end
        r_done_pulses++;
      end
      @(posedge clk); #1;
    end
    seg_wr_en = 1'b0;
    start = 1'b0;
    pix_bus.plot_ready = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (pix_bus.plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %b want 0", pix_bus.plot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({pix_bus.x, pix_bus.y, pix_bus.colour} !== 18'd0) begin
      errors++; $display("FAIL reset_xyc: got (%0d,%0d,%0d) want (0,0,0)", pix_bus.x, pix_bus.y, pix_bus.colour);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    for (int i = 0; i < 10; i++) set_model(i, 0, 0, 0, 0, 0);
  endtask

  task automatic test_single();
    int ec;
    pix_t o, e;
    wr_seg(0, 100, 20, 2, 60, 7);
    do_start(2'b00, 0, ec);
    run_draw(400, 1, 0, 0, '0, 0);
    checks++; if (r_done_pulses !== 1) begin errors++; $display("FAIL single_done_pulses: got %0d want 1", r_done_pulses); end
    checks++; if (r_done_cyc !== 123) begin errors++; $display("FAIL single_latency: got %0d want 123", r_done_cyc); end
    checks++; if (r_plot_cyc !== 120) begin errors++; $display("FAIL single_plot_cycles: got %0d want 120", r_plot_cyc); end
    checks++; if (r_busy_at_done !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got 1 want 0"); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== pix_t'{8'd100, 7'd20, 3'd7}) begin
        errors++; $display("FAIL single_first: got (%0d,%0d) want (100,20)", obs_q[0].x, obs_q[0].y);
      end
      checks++; if (obs_q[$] !== pix_t'{8'd101, 7'd79, 3'd7}) begin
        errors++; $display("FAIL single_last: got (%0d,%0d) want (101,79)", obs_q[$].x, obs_q[$].y);
      end
    end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_pix: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.x, o.y, o.c, e.x, e.y, e.c); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_cumulative();
    int ec;
    pix_t o, e;
    wr_seg(1, 10, 5, 3, 2, 1);
    wr_seg(2, 20, 30, 1, 4, 2);
    wr_seg(3, 150, 100, 3, 2, 4);
    do_start(2'b01, 3, ec);
    run_draw(600, 1, 0, 0, '0, 0);
    checks++; if (r_done_pulses !== 1) begin errors++; $display("FAIL cumul_done_pulses: got %0d want 1", r_done_pulses); end
    checks++; if (r_done_cyc !== 145) begin errors++; $display("FAIL cumul_latency: got %0d want 145", r_done_cyc); end
    checks++; if (r_plot_cyc !== 136) begin errors++; $display("FAIL cumul_plot_cycles: got %0d want 136", r_plot_cyc); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL cumul_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL cumul_pix: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.x, o.y, o.c, e.x, e.y, e.c); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_erase();
    int ec;
    pix_t o, e;
    do_start(2'b10, 0, ec);
    run_draw(400, 1, 0, 0, '0, 0);
    checks++; if (r_done_cyc !== ec) begin errors++; $display("FAIL erase_latency: got %0d want %0d", r_done_cyc, ec); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL erase_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL erase_pix: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.x, o.y, o.c, e.x, e.y, e.c); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_boundary();
    int ec;
    pix_t o, e;
    wr_seg(4, 158, 118, 4, 4, 5);
    do_start(2'b00, 4, ec);
    run_draw(100, 1, 0, 0, '0, 0);
    checks++; if (r_plot_cyc !== 4) begin errors++; $display("FAIL edge_plot_cycles: got %0d want 4", r_plot_cyc); end
    checks++; if (r_done_cyc !== 19) begin errors++; $display("FAIL edge_latency: got %0d want 19", r_done_cyc); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL edge_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL edge_pix: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.x, o.y, o.c, e.x, e.y, e.c); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int ec;
    pix_t o, e;
    wr_seg(5, 30, 40, 3, 1, 6);
    do_start(2'b00, 5, ec);
    run_draw(100, 3, 0, 0, '0, 0);
    checks++; if (r_done_pulses !== 1) begin errors++; $display("FAIL bp_done_pulses: got %0d want 1", r_done_pulses); end
    checks++; if (r_held_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d moves while stalled want 0", r_held_bad); end
    checks++; if (obs_q.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d want 3", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bp_pix: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.x, o.y, o.c, e.x, e.y, e.c); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // Rewrite the active segment and re-pulse start mid-draw; neither may disturb it
  task automatic test_back_to_back();
    int ec;
    pix_t o, e;
    do_start(2'b00, 5, ec);
    run_draw(100, 1, 2, 5, pack_seg(0, 0, 1, 1, 1), 3);
    set_model(5, 0, 0, 1, 1, 1);
    checks++; if (r_done_pulses !== 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 1", r_done_pulses); end
    checks++; if (r_done_cyc !== 6) begin errors++; $display("FAIL b2b_latency: got %0d want 6", r_done_cyc); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_pix: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.x, o.y, o.c, e.x, e.y, e.c); end
    end
    obs_q.delete(); exp_q.delete();
    do_start(2'b00, 5, ec);
    run_draw(100, 1, 0, 0, '0, 0);
    checks++; if (obs_q.size() !== 1 || obs_q[0] !== pix_t'{8'd0, 7'd0, 3'd1}) begin
      errors++; $display("FAIL b2b_new_seg: got %0d pixels want 1 at (0,0,1)", obs_q.size());
    end
    checks++; if (r_done_cyc !== 4) begin errors++; $display("FAIL b2b_new_latency: got %0d want 4", r_done_cyc); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_clamp();
    int ec;
    pix_t o, e;
    wr_seg(12, 1, 1, 5, 5, 7);
    wr_seg(9, 5, 6, 2, 1, 2);
    do_start(2'b00, 15, ec);
    run_draw(100, 1, 0, 0, '0, 0);
    checks++; if (r_done_cyc !== 5) begin errors++; $display("FAIL clamp_latency: got %0d want 5", r_done_cyc); end
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL clamp_count: got %0d want 2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL clamp_pix: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.x, o.y, o.c, e.x, e.y, e.c); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int ec;
    do_start(2'b00, 0, ec);
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (pix_bus.plot !== 1'b0) begin errors++; $display("FAIL rstmid_plot: got %b want 0", pix_bus.plot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 10; i++) set_model(i, 0, 0, 0, 0, 0);
    do_start(2'b00, 0, ec);
    run_draw(50, 1, 0, 0, '0, 0);
    checks++; if (r_done_cyc !== 3) begin errors++; $display("FAIL rstmid_latency: got %0d want 3", r_done_cyc); end
    checks++; if (r_plot_cyc !== 0) begin errors++; $display("FAIL rstmid_plots: got %0d want 0", r_plot_cyc); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    resetn = 1'b1; start = 1'b0; mode = 2'b00; part_idx = '0;
    seg_wr_en = 1'b0; seg_wr_addr = '0; seg_wr_data = '0;
    pix_bus.plot_ready = 1'b1;
    test_reset();
    test_single();
    test_cumulative();
    test_erase();
    test_boundary();
    test_backpressure();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
